// File: rtl/music_recorder_pkg.sv
// Shared definitions for the music recorder: global mode encodings,
// default record geometry and the recorder state encoding.
package music_recorder_pkg;

  // Global operating modes; the recorder is only active in FREE
  localparam int unsigned STATE_WIDTH = 3;
  localparam logic [STATE_WIDTH-1:0] FREE     = 3'd0;
  localparam logic [STATE_WIDTH-1:0] AUTOPLAY = 3'd1;
  localparam logic [STATE_WIDTH-1:0] LEARNING = 3'd2;
  localparam logic [STATE_WIDTH-1:0] GAME     = 3'd3;

  // Default record geometry shared with the music memories
  localparam int unsigned NOTE_WIDTH_DEF = 8;
  localparam int unsigned DUR_WIDTH_DEF  = 8;
  localparam int unsigned DATA_WIDTH     = NOTE_WIDTH_DEF + DUR_WIDTH_DEF;
  localparam int unsigned MAX_DEPTH_BIT  = 10;

  // Recorder state encoding
  typedef enum logic [2:0] {
    REC_IDLE   = 3'd0,
    REC_ARMED  = 3'd1,
    REC_NOTE   = 3'd2,
    REC_COMMIT = 3'd3,
    REC_TERM   = 3'd4
  } rec_state_e;

  // True when the global mode allows recording
  function automatic logic is_free(input logic [STATE_WIDTH-1:0] st);
    return st == FREE;
  endfunction

endpackage

// File: rtl/music_recorder_tick_gen.sv
// Duration-tick prescaler: one-cycle tick every TICK_DIV clocks,
// restartable with a synchronous clear so a new note starts a full tick.
module music_recorder_tick_gen #(
  parameter int unsigned TICK_DIV = 2_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Tick on terminal count; wrap on tick, restart on clear
  always_comb begin
    tick_c = (cnt_q == CNT_LAST);
    cnt_d  = cnt_q + CNT_W'(1);
    if (clr || tick_c) begin
      cnt_d = '0;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/music_recorder.sv
// Keyboard recorder: times notes played in FREE mode and streams
// {note, duration} records plus a {0,0} terminator into a music memory.
// Optional feature macro: MUSIC_REC_REST_EN (also record silences as {0,dur}).
module music_recorder
  import music_recorder_pkg::*;
#(
  parameter int unsigned NOTE_WIDTH = NOTE_WIDTH_DEF,
  parameter int unsigned DUR_WIDTH  = DUR_WIDTH_DEF,
  parameter int unsigned TICK_DIV   = 2_500_000,
  parameter int unsigned DEPTH_BIT  = MAX_DEPTH_BIT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [STATE_WIDTH-1:0]          current_state,
  input  logic                            rec_start,
  input  logic                            rec_stop,
  input  logic [NOTE_WIDTH-1:0]           key_note,
  output logic                            write_en,
  output logic [NOTE_WIDTH+DUR_WIDTH-1:0] data_in,
  output logic [DEPTH_BIT-1:0]            wr_addr,
  output logic [DEPTH_BIT-1:0]            duration,
  output logic                            busy,
  output logic                            full
);

  localparam int unsigned REC_W = NOTE_WIDTH + DUR_WIDTH;
  localparam logic [DUR_WIDTH-1:0] DUR_MAX   = '1;
  localparam logic [DEPTH_BIT-1:0] ADDR_LAST = '1;

  rec_state_e             state_q, state_d;
  logic [NOTE_WIDTH-1:0]  note_q, note_d;
  logic [DUR_WIDTH-1:0]   dur_q, dur_d;
  logic                   stop_after_q, stop_after_d;
  logic                   write_en_q, write_en_d;
  logic [REC_W-1:0]       data_in_q, data_in_d;
  logic [DEPTH_BIT-1:0]   wr_addr_q, wr_addr_d;
  logic [DEPTH_BIT-1:0]   duration_q, duration_d;
  logic                   busy_q, busy_d;
  logic                   full_q, full_d;

  logic                   tick_c;
  logic                   tick_clr_c;
  logic                   stop_c;
  logic [DUR_WIDTH-1:0]   dur_inc_c;
  logic [DUR_WIDTH-1:0]   commit_dur_c;
  logic [DEPTH_BIT-1:0]   duration_inc_c;

  music_recorder_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_rec_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .clr    (tick_clr_c),
    .tick_c (tick_c)
  );

  // Derived terms: stop request, tick-inclusive duration, saturating record count
  always_comb begin
    stop_c         = rec_stop || !is_free(current_state);
    dur_inc_c      = dur_q + DUR_WIDTH'(tick_c);
    commit_dur_c   = (dur_inc_c == '0) ? DUR_WIDTH'(1) : dur_inc_c;
    duration_inc_c = (duration_q == ADDR_LAST) ? duration_q : duration_q + DEPTH_BIT'(1);
  end

  // Recorder FSM: next state, capture and write strobes
  always_comb begin
    state_d      = state_q;
    note_d       = note_q;
    dur_d        = dur_q;
    stop_after_d = stop_after_q;
    write_en_d   = 1'b0;
    data_in_d    = data_in_q;
    wr_addr_d    = wr_addr_q;
    duration_d   = duration_q;
    full_d       = full_q;
    tick_clr_c   = 1'b0;

    unique case (state_q)
      REC_IDLE: begin
        if (rec_start && !stop_c) begin
          state_d      = REC_ARMED;
          wr_addr_d    = '0;
          duration_d   = '0;
          full_d       = 1'b0;
          stop_after_d = 1'b0;
        end
      end

      REC_ARMED: begin
        if (stop_c) begin
          state_d    = REC_TERM;
          write_en_d = 1'b1;
          data_in_d  = '0;
        end else if (key_note != '0) begin
          state_d    = REC_NOTE;
          note_d     = key_note;
          dur_d      = '0;
          tick_clr_c = 1'b1;
        end
      end

      REC_NOTE: begin
        dur_d = dur_inc_c;
        if (stop_c || (key_note != note_q) || (dur_inc_c == DUR_MAX)) begin
          state_d      = REC_COMMIT;
          write_en_d   = 1'b1;
          data_in_d    = {note_q, commit_dur_c};
          stop_after_d = stop_c;
        end
      end

      REC_COMMIT: begin
        wr_addr_d  = wr_addr_q + DEPTH_BIT'(1);
        duration_d = duration_inc_c;
        if (wr_addr_d == ADDR_LAST) begin
          // Last slot is kept for the terminator
          full_d     = 1'b1;
          state_d    = REC_TERM;
          write_en_d = 1'b1;
          data_in_d  = '0;
        end else if (stop_after_q || stop_c) begin
          state_d    = REC_TERM;
          write_en_d = 1'b1;
          data_in_d  = '0;
        end else begin
`ifdef MUSIC_REC_REST_EN
          state_d    = REC_NOTE;
          note_d     = key_note;
          dur_d      = '0;
          tick_clr_c = 1'b1;
`else
          if (key_note != '0) begin
            state_d    = REC_NOTE;
            note_d     = key_note;
            dur_d      = '0;
            tick_clr_c = 1'b1;
          end else begin
            state_d = REC_ARMED;
          end
`endif
        end
      end

      REC_TERM: begin
        duration_d   = duration_inc_c;
        stop_after_d = 1'b0;
        state_d      = REC_IDLE;
      end

      default: begin
        state_d = REC_IDLE;
      end
    endcase

    busy_d = (state_d != REC_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= REC_IDLE;
      note_q       <= '0;
      dur_q        <= '0;
      stop_after_q <= 1'b0;
      write_en_q   <= 1'b0;
      data_in_q    <= '0;
      wr_addr_q    <= '0;
      duration_q   <= '0;
      busy_q       <= 1'b0;
      full_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      note_q       <= note_d;
      dur_q        <= dur_d;
      stop_after_q <= stop_after_d;
      write_en_q   <= write_en_d;
      data_in_q    <= data_in_d;
      wr_addr_q    <= wr_addr_d;
      duration_q   <= duration_d;
      busy_q       <= busy_d;
      full_q       <= full_d;
    end
  end

  assign write_en = write_en_q;
  assign data_in  = data_in_q;
  assign wr_addr  = wr_addr_q;
  assign duration = duration_q;
  assign busy     = busy_q;
  assign full     = full_q;

endmodule
